// File: rtl/dither_rgb.sv
`default_nettype none
// ============================================================================
// Module   : dither_rgb
// Purpose  : Per-channel colour depth reduction from IN_W to OUT_W bits with
//            three selectable modes: truncation, error diffusion along the
//            line, and ordered 4x4 Bayer dithering. One-cycle latency.
// Ports    : clk          - clock, rising edge
//            rst          - synchronous active-high reset
//            frame_start  - one-cycle pulse at the start of a frame
//            visible      - pixel_in holds an active-area pixel
//            mode         - requested mode, taken only on frame_start
//                           (00/11 truncate, 01 error diffusion, 10 Bayer)
//            pixel_in     - CH channels of IN_W bits, channel 0 in the LSBs
//            pixel_out    - CH channels of OUT_W bits, registered
//            valid_out    - visible delayed by one cycle
// Revision : 1.0 - initial release
// ============================================================================
module dither_rgb #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4,
    parameter int CH    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  visible,
    input  logic [1:0]            mode,
    input  logic [CH*IN_W-1:0]    pixel_in,
    output logic [CH*OUT_W-1:0]   pixel_out,
    output logic                  valid_out
);

    localparam int D  = IN_W - OUT_W;
    // in + err spans [-2^(D-1), 2^IN_W + 2^D - 2]; two extra bits hold it.
    localparam int SW = IN_W + 2;

    localparam logic [1:0] c_MODE_ED    = 2'b01;
    localparam logic [1:0] c_MODE_BAYER = 2'b10;

    localparam logic [3:0] c_BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    logic [1:0]             r_mode;
    logic [1:0]             r_x;
    logic [1:0]             r_y;
    logic [3:0]             w_t;
    logic [D-1:0]           w_ts;
    logic [CH*OUT_W-1:0]    w_code_all;

    assign w_t = c_BAYER[{r_y, r_x}];

    // ts = floor(t * 2^D / 16); always below 2^D so D bits are enough.
    if (D >= 4) begin : g_ts_shl
        assign w_ts = D'(w_t) << (D - 4);
    end else begin : g_ts_shr
        assign w_ts = D'(w_t >> (4 - D));
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [IN_W-1:0]        w_in;
        logic signed [D:0]      r_err;
        logic signed [SW-1:0]   w_sum;
        logic [IN_W-1:0]        w_c;
        logic [OUT_W:0]         w_rnd;
        logic [OUT_W-1:0]       w_ed_code;
        logic [D:0]             w_err_next;
        logic [IN_W:0]          w_bsum;
        logic [OUT_W-1:0]       w_by_code;
        logic [OUT_W-1:0]       w_tr_code;

        assign w_in  = pixel_in[g*IN_W +: IN_W];
        assign w_sum = $signed({2'b00, w_in})
                     + $signed({{(SW-D-1){r_err[D]}}, r_err});

        always_comb begin
            w_c = w_sum[IN_W-1:0];
            if (w_sum[SW-1]) begin
                w_c = '0;
            end else if (w_sum[IN_W]) begin
                w_c = '1;
            end
        end

        // Round half up: the fraction is >= one half exactly when its MSB is set.
        assign w_rnd     = {1'b0, w_c[IN_W-1:D]} + {{OUT_W{1'b0}}, w_c[D-1]};
        assign w_ed_code = w_rnd[OUT_W] ? '1 : w_rnd[OUT_W-1:0];

        // The residual always fits in D+1 signed bits, so modular arithmetic
        // on the low D+1 bits of c and code*2^D gives the exact value.
        assign w_err_next = w_c[D:0] - {w_ed_code[0], {D{1'b0}}};

        assign w_bsum    = {1'b0, w_in} + {{(OUT_W+1){1'b0}}, w_ts};
        assign w_by_code = w_bsum[IN_W] ? '1 : w_bsum[IN_W-1:D];

        assign w_tr_code = w_in[IN_W-1:D];

        assign w_code_all[g*OUT_W +: OUT_W] =
            (r_mode == c_MODE_ED)    ? w_ed_code :
            (r_mode == c_MODE_BAYER) ? w_by_code : w_tr_code;

        // The error runs in every mode so a mode switch starts from valid state.
        always_ff @(posedge clk) begin
            if (rst || !visible) begin
                r_err <= '0;
            end else begin
                r_err <= w_err_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode    <= 2'b00;
            r_x       <= 2'd0;
            r_y       <= 2'd0;
            pixel_out <= '0;
            valid_out <= 1'b0;
        end else begin
            if (frame_start) begin
                r_mode <= mode;
            end

            r_x <= visible ? r_x + 2'd1 : 2'd0;

            // valid_out is last cycle's visible, so this catches the line end.
            if (frame_start) begin
                r_y <= 2'd0;
            end else if (valid_out && !visible) begin
                r_y <= r_y + 2'd1;
            end

            pixel_out <= visible ? w_code_all : '0;
            valid_out <= visible;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dither_rgb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dither_rgb
// Purpose  : Self-checking bench for dither_rgb (IN_W=8, OUT_W=4, CH=3).
//            A driver applies directed vectors and queues the hand-computed
//            response; a monitor pops and compares one entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dither_rgb;

    typedef struct {
        logic        v;
        logic [11:0] p;
        int          id;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        visible;
    logic [1:0]  mode;
    logic [23:0] pixel_in;
    logic [11:0] pixel_out;
    logic        valid_out;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    dither_rgb #(.IN_W(8), .OUT_W(4), .CH(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .visible     (visible),
        .mode        (mode),
        .pixel_in    (pixel_in),
        .pixel_out   (pixel_out),
        .valid_out   (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of stimulus and queue the response expected after the
    // next rising edge.
    task automatic step(input logic r, input logic fs, input logic vis,
                        input logic [1:0] m, input logic [23:0] pix,
                        input logic [11:0] e);
        exp_t x;
        @(negedge clk);
        rst         = r;
        frame_start = fs;
        visible     = vis;
        mode        = m;
        pixel_in    = pix;
        x.v  = !r && vis;
        x.p  = e;
        x.id = vec_id;
        vec_id++;
        q.push_back(x);
    endtask

    task automatic line(input logic [1:0] m, input logic [23:0] pix,
                        input int n, input logic [47:0] codes);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, m, pix, codes[47-12*i -: 12]);
        end
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks++;
                if (valid_out !== x.v || pixel_out !== x.p) begin
                    errors++;
                    $display("FAIL vec%0d: got valid=%b pixel=%03h, expected valid=%b pixel=%03h",
                             x.id, valid_out, pixel_out, x.v, x.p);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; frame_start = 1'b0; visible = 1'b0; mode = 2'b00; pixel_in = '0;

        // Reset overrides visible and frame_start.
        step(1, 0, 1, 2'b00, 24'h5F5F5F, 12'h000);
        step(1, 1, 1, 2'b01, 24'h080808, 12'h000);

        // Mode register came out of reset as truncate.
        step(0, 0, 1, 2'b01, 24'h5F5F5F, 12'h555);
        step(0, 0, 1, 2'b01, 24'h123456, 12'h135);
        step(0, 0, 1, 2'b01, 24'hFF00A7, 12'hF0A);
        step(0, 0, 0, 2'b01, 24'hFFFFFF, 12'h000);

        // Mode request without frame_start is ignored.
        line(2'b01, 24'h080808, 4, {12'h000, 12'h000, 12'h000, 12'h000});
        step(0, 1, 0, 2'b01, 24'h000000, 12'h000);

        // Error diffusion.
        line(2'b01, 24'h080808, 4, {12'h111, 12'h000, 12'h111, 12'h000});
        step(0, 0, 0, 2'b01, 24'h000000, 12'h000);
        line(2'b01, 24'hFFFFFF, 3, {12'hFFF, 12'hFFF, 12'hFFF, 12'h000});
        step(0, 0, 0, 2'b01, 24'h000000, 12'h000);
        line(2'b01, 24'h1808FF, 2, {12'h21F, 12'h10F, 24'h0});
        step(0, 0, 0, 2'b01, 24'h000000, 12'h000);

        // Reset mid-line discards error.
        line(2'b01, 24'h080808, 1, {12'h111, 36'h0});
        step(1, 0, 1, 2'b01, 24'h080808, 12'h000);
        step(0, 1, 0, 2'b01, 24'h000000, 12'h000);
        line(2'b01, 24'h080808, 1, {12'h111, 36'h0});

        // Bayer; frame_start coincides with the line end and wins over y++.
        step(0, 1, 0, 2'b10, 24'h000000, 12'h000);
        line(2'b10, 24'h080808, 4, {12'h000, 12'h111, 12'h000, 12'h111});
        line(2'b10, 24'h080808, 1, {12'h000, 36'h0});
        step(0, 0, 0, 2'b10, 24'h000000, 12'h000);
        line(2'b10, 24'h080808, 4, {12'h111, 12'h000, 12'h111, 12'h000});
        step(0, 0, 0, 2'b10, 24'h000000, 12'h000);
        line(2'b10, 24'h080808, 4, {12'h000, 12'h111, 12'h000, 12'h111});
        step(0, 0, 0, 2'b10, 24'h000000, 12'h000);
        step(0, 0, 1, 2'b10, 24'h000000, 12'h000);
        step(0, 0, 1, 2'b10, 24'hFFFFFF, 12'hFFF);
        step(0, 0, 0, 2'b10, 24'h000000, 12'h000);
        // y wrapped back to row 0.
        line(2'b10, 24'h080808, 2, {12'h000, 12'h111, 24'h0});
        line(2'b10, 24'h000000, 2, {12'h000, 12'h000, 24'h0});

        // Mode 11 truncates.
        step(0, 1, 0, 2'b11, 24'h000000, 12'h000);
        step(0, 0, 1, 2'b11, 24'h5F5F5F, 12'h555);
        step(0, 0, 0, 2'b11, 24'h000000, 12'h000);

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left, expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
